// File: rtl/qam_symbol_scheduler.sv
// Splits payload words LSB-first into 1/2/4-bit QAM symbols and issues each one
// to the selected modulator over a valid/ready handshake.
module qam_symbol_scheduler #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [2:0]        qam,
    output logic [3:0]        sym_out,
    output logic [2:0]        sym_bits,
    output logic [2:0]        sym_sel,
    output logic              sym_valid,
    input  logic              mod_ready,
    output logic              word_done,
    output logic              error
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t            state_r;
    logic [WORD_W-1:0] shift_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [3:0]        sym_out_r;
    logic [2:0]        sym_bits_r;
    logic [2:0]        sym_sel_r;
    logic              word_ready_r;
    logic              sym_valid_r;
    logic              word_done_r;
    logic              error_r;

    logic              accept_s;
    logic              xfer_s;
    logic              last_s;
    logic [WORD_W-1:0] shifted_s;

    function automatic logic [2:0] mode_bps(input logic [2:0] mode);
        case (mode)
            3'd1:    return 3'd2;
            3'd2:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [2:0] mode_sel(input logic [2:0] mode);
        case (mode)
            3'd1:    return 3'b010;
            3'd2:    return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic mode_illegal(input logic [2:0] mode);
        return (mode > 3'd2);
    endfunction

    function automatic logic [CNT_W-1:0] sym_count(input logic [2:0] bps);
        case (bps)
            3'd2:    return CNT_W'(WORD_W / 2);
            3'd4:    return CNT_W'(WORD_W / 4);
            default: return CNT_W'(WORD_W);
        endcase
    endfunction

    function automatic logic [3:0] slice_sym(input logic [WORD_W-1:0] w, input logic [2:0] bps);
        case (bps)
            3'd2:    return {2'b00, w[1:0]};
            3'd4:    return w[3:0];
            default: return {3'b000, w[0]};
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] shift_word(input logic [WORD_W-1:0] w, input logic [2:0] bps);
        case (bps)
            3'd2:    return {2'b00, w[WORD_W-1:2]};
            3'd4:    return {4'b0000, w[WORD_W-1:4]};
            default: return {1'b0, w[WORD_W-1:1]};
        endcase
    endfunction

    // Handshake qualifiers and the next shift-register value.
    always_comb begin
        accept_s  = 1'b0;
        xfer_s    = 1'b0;
        last_s    = 1'b0;
        shifted_s = shift_word(shift_r, sym_bits_r);
        if (state_r == ST_IDLE) begin
            accept_s = word_valid & word_ready_r;
        end else begin
            xfer_s = sym_valid_r & mod_ready;
            last_s = xfer_s & (cnt_r == CNT_W'(1));
        end
    end

    // Word/symbol sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            shift_r      <= '0;
            cnt_r        <= '0;
            sym_out_r    <= 4'd0;
            sym_bits_r   <= 3'd1;
            sym_sel_r    <= 3'b001;
            word_ready_r <= 1'b0;
            sym_valid_r  <= 1'b0;
            word_done_r  <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    word_done_r <= 1'b0;
                    if (accept_s) begin
                        shift_r      <= word_in;
                        sym_out_r    <= slice_sym(word_in, mode_bps(qam));
                        sym_bits_r   <= mode_bps(qam);
                        sym_sel_r    <= mode_sel(qam);
                        cnt_r        <= sym_count(mode_bps(qam));
                        error_r      <= error_r | mode_illegal(qam);
                        word_ready_r <= 1'b0;
                        sym_valid_r  <= 1'b1;
                        state_r      <= ST_SEND;
                    end else begin
                        word_ready_r <= 1'b1;
                        sym_valid_r  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        shift_r   <= shifted_s;
                        sym_out_r <= slice_sym(shifted_s, sym_bits_r);
                        cnt_r     <= cnt_r - CNT_W'(1);
                        if (last_s) begin
                            word_done_r  <= 1'b1;
                            sym_valid_r  <= 1'b0;
                            word_ready_r <= 1'b1;
                            state_r      <= ST_IDLE;
                        end else begin
                            word_done_r <= 1'b0;
                        end
                    end else begin
                        word_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    sym_valid_r  <= 1'b0;
                    word_ready_r <= 1'b0;
                    word_done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign word_ready = word_ready_r;
    assign sym_out    = sym_out_r;
    assign sym_bits   = sym_bits_r;
    assign sym_sel    = sym_sel_r;
    assign sym_valid  = sym_valid_r;
    assign word_done  = word_done_r;
    assign error      = error_r;

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Randomized bench for qam_symbol_scheduler; expected symbols are derived
// directly from the word, the mode and the symbol index.
module tb_qam_symbol_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  qam;
    logic [3:0]  sym_out;
    logic [2:0]  sym_bits;
    logic [2:0]  sym_sel;
    logic        sym_valid;
    logic        mod_ready;
    logic        word_done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;
    logic err_exp = 1'b0;

    always #5 clk = ~clk;

    qam_symbol_scheduler #(.WORD_W(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .qam(qam), .sym_out(sym_out), .sym_bits(sym_bits),
        .sym_sel(sym_sel), .sym_valid(sym_valid), .mod_ready(mod_ready),
        .word_done(word_done), .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int ref_bps(input int q);
        if (q == 1) return 2;
        if (q == 2) return 4;
        return 1;
    endfunction

    function automatic int ref_sel(input int q);
        if (q == 1) return 2;
        if (q == 2) return 4;
        return 1;
    endfunction

    task automatic check_reset_outputs();
        chk("rst_word_ready", word_ready, 0);
        chk("rst_sym_valid", sym_valid, 0);
        chk("rst_sym_out", sym_out, 0);
        chk("rst_sym_bits", sym_bits, 1);
        chk("rst_sym_sel", sym_sel, 1);
        chk("rst_word_done", word_done, 0);
        chk("rst_error", error, 0);
    endtask

    // rmode: 0 = mod_ready always 1, 1 = random, 2 = pattern 1,0,0,...
    // stop_after >= 0 returns once that many symbols have been transferred.
    task automatic send_word(input logic [31:0] w, input int q, input int rmode, input int stop_after);
        int bps;
        int n;
        int idx;
        int cyc;
        logic [31:0] mask;
        logic [31:0] exp_sym;
        bps  = ref_bps(q);
        n    = 32 / bps;
        mask = (32'd1 << bps) - 32'd1;
        idx  = 0;
        cyc  = 0;
        while (word_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("word_ready_idle", word_ready, 1);
        chk("sym_valid_idle", sym_valid, 0);
        word_in    = w;
        qam        = q[2:0];
        word_valid = 1'b1;
        mod_ready  = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (q > 2) err_exp = 1'b1;
        chk("word_ready_busy", word_ready, 0);
        cyc = 0;
        while (idx < n && cyc < 400) begin
            word_valid = 1'($urandom_range(0, 1));
            word_in    = $urandom;
            qam        = 3'($urandom_range(0, 7));
            exp_sym    = (w >> (idx * bps)) & mask;
            chk("sym_valid", sym_valid, 1);
            chk("sym_out", sym_out, exp_sym);
            chk("sym_bits", sym_bits, bps);
            chk("sym_sel", sym_sel, ref_sel(q));
            chk("word_done_mid", word_done, 0);
            chk("error", error, err_exp);
            if (stop_after >= 0 && idx == stop_after) begin
                word_valid = 1'b0;
                return;
            end
            case (rmode)
                0:       mod_ready = 1'b1;
                1:       mod_ready = 1'($urandom_range(0, 1));
                default: mod_ready = (cyc % 3 == 0);
            endcase
            @(negedge clk);
            if (mod_ready) idx++;
            cyc++;
        end
        word_valid = 1'b0;
        chk("xfer_count", idx, n);
        chk("word_done_end", word_done, 1);
        chk("sym_valid_end", sym_valid, 0);
        chk("word_ready_end", word_ready, 1);
        chk("sym_bits_hold", sym_bits, bps);
        chk("sym_sel_hold", sym_sel, ref_sel(q));
        chk("error_end", error, err_exp);
        mod_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        rst        = 1'b0;
        word_in    = 32'd0;
        word_valid = 1'b0;
        qam        = 3'd0;
        mod_ready  = 1'b0;
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("word_ready_first", word_ready, 1);

        send_word(32'hA5A5A5A5, 0, 0, -1);
        send_word(32'h0000001B, 1, 0, -1);
        send_word(32'h12345678, 2, 2, -1);
        send_word(32'hFFFF0000, 5, 0, -1);
        send_word(32'h9ABCDEF0, 2, 1, -1);
        send_word(32'h3C3C3C3C, 1, 1, -1);

        // Reset in the middle of a word.
        send_word(32'hCAFEBABE, 2, 0, 5);
        #2;
        rst = 1'b0;
        #1;
        err_exp = 1'b0;
        check_reset_outputs();
        @(negedge clk);
        rst        = 1'b1;
        mod_ready  = 1'b1;
        word_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_sym_valid", sym_valid, 0);
            chk("post_rst_word_ready", word_ready, 1);
            chk("post_rst_sym_out", sym_out, 0);
        end
        send_word(32'h0F1E2D3C, 2, 1, -1);

        for (int k = 0; k < 20; k++) begin
            send_word($urandom, int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qam_symbol_scheduler.md
Name: qam_symbol_scheduler

Overview:
Sequences 32-bit payload words into constellation symbols for the QAM modulator bank (qam_2 / qam_4 / qam_16). Accepts words over a valid/ready handshake and latches the modulation mode once per word. Slices each word LSB-first into 1-, 2- or 4-bit symbols and issues each symbol with a one-hot modulator select under a valid/ready handshake. Sits between the payload source and the modulator instances.

Parameters:
WORD_W, 32, payload word width; must be a multiple of 4.
CNT_W, 6, symbol down-counter width; must hold WORD_W.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
word_in  in  WORD_W  payload word
word_valid  in  1  word_in valid
word_ready  out  1  scheduler can accept a word
qam  in  3  mode select: 0=QAM2 (1 bit/sym), 1=QAM4 (2), 2=QAM16 (4), 3..7 illegal
sym_out  out  4  current symbol, right-aligned, unused MSBs zero
sym_bits  out  3  bits per symbol of the current word (1, 2 or 4)
sym_sel  out  3  one-hot modulator select: [0]=qam_2, [1]=qam_4, [2]=qam_16
sym_valid  out  1  sym_out/sym_sel valid
mod_ready  in  1  modulator accepts a symbol this cycle
word_done  out  1  one-cycle pulse on the last symbol transfer of a word
error  out  1  sticky illegal-mode flag

Behaviour:
- Reset (rst=0, async): state=IDLE, word_ready=0, sym_valid=0, sym_out=0, sym_bits=1, sym_sel=3'b001, word_done=0, error=0, shift register=0, counter=0.
  - First cycle after release: word_ready=1.
- FSM has two states:
  - IDLE: word_ready=1, sym_valid=0.
  - SEND: word_ready=0, sym_valid=1.
- Word accept happens on word_valid & word_ready in IDLE. On the same edge:
  - Load the shift register with word_in.
  - Latch the mode from qam: 0 gives bps=1, sel=001; 1 gives bps=2, sel=010; 2 gives bps=4, sel=100.
  - qam=3..7 maps to bps=1, sel=001 and sets error=1.
  - Load the counter with WORD_W/bps (32/16/8).
  - Move to SEND.
- Latency: sym_valid asserts the cycle after accept. No combinational path from word_valid to sym_valid.
- sym_out = shift_reg[bps-1:0], zero-extended to 4 bits.
- Symbol transfer happens on sym_valid & mod_ready. On that edge the shift register shifts right by bps (zero fill) and the counter decrements.
  - When the counter reaches 1 at a transfer (last symbol): word_done=1 for that one cycle, next state=IDLE, sym_valid=0.
- Backpressure: while mod_ready=0 in SEND, sym_out, sym_sel, sym_bits and the counter all hold.
- qam is ignored outside the accept edge. A mid-word mode change takes effect only on the next word.
- sym_bits and sym_sel hold their last latched value in IDLE.
- Per-word throughput: N symbol cycles (with mod_ready=1) plus one IDLE bubble.
- error stays high until reset and does not block operation.
- Reset asserted mid-word discards the word entirely. No symbols are emitted after reset release until a new word is accepted.
- mod_ready is ignored in IDLE.
- word_valid while in SEND has no effect. The source must hold word_in until accepted.

Test Plan:
- qam=0, word 0xA5A5A5A5, mod_ready=1 -> 32 symbols, first 8 are 1,0,1,0,0,1,0,1. sym_sel=001. word_done pulses on the 32nd transfer. word_ready returns 1 the next cycle.
- qam=1, word 0x0000001B -> 16 symbols: 3,2,1, then 13 zeros. sym_bits=2, sym_sel=010, error=0.
- qam=2, word 0x12345678, mod_ready toggled 1,0,0,1,... -> symbols 8,7,6,5,4,3,2,1 in order. Each symbol holds while mod_ready=0. Exactly 8 transfers.
- qam=5 at accept, word 0xFFFF0000 -> error=1 and stays 1. 32 one-bit symbols (16 zeros, then 16 ones). sym_sel=001.
- qam switched 2->1 after 3 symbols of a QAM16 word -> that word completes with 8 four-bit symbols. The next word uses 2-bit symbols (16 symbols).
- rst pulsed low after 5 symbols -> outputs go to reset values immediately (async). After release no symbols are emitted until a new word, and the new word starts at its bit 0.
